// File: rtl/fetch_stage.sv
// IF stage and IF/ID register of the 5-stage MIPS core, with a one-entry skid buffer for stalls.
// Optional `DELAY_SLOT_EN: deliver the instruction after a taken redirect instead of squashing it.
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESETN,
  output logic        IMREQ,
  output logic [31:0] IMADDR,
  input  logic [31:0] IMRDATA,
  input  logic        IMRDY,
  input  logic        WPCIR,
  input  logic        BRANCH,
  input  logic        JUMP,
  input  logic        JR,
  input  logic [31:0] JRTGT,
  output logic [31:0] IDIR,
  output logic [31:0] IDPC4,
  output logic        IDVALID
);

`ifdef DELAY_SLOT_EN
  localparam bit SLOT_DELIVER = 1'b1;
`else
  localparam bit SLOT_DELIVER = 1'b0;
`endif

  typedef enum logic [1:0] {S_FETCH, S_DISCARD, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic        run_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc4_q, pc4_d;
  logic        vld_q, vld_d;
  logic [31:0] buf_ir_q, buf_ir_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;

  logic        take, rdy, slot_load;
  logic [31:0] pc_plus4, br_tgt, tgt, slot_ir, slot_pc4;

  // Redirect target and slot-word source
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    br_tgt   = pc4_q + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    if (JR)        tgt = JRTGT;
    else if (JUMP) tgt = {pc4_q[31:28], ir_q[25:0], 2'b00};
    else           tgt = br_tgt;
    if (state_q == S_HOLD) begin
      slot_ir  = buf_ir_q;
      slot_pc4 = buf_pc4_q;
    end else begin
      slot_ir  = IMRDATA;
      slot_pc4 = pc_plus4;
    end
  end

  assign take = BRANCH & vld_q & ~WPCIR;
  // A response only counts while a request is actually outstanding (not in HOLD, not right after reset)
  assign rdy  = IMRDY & IMREQ;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= S_FETCH;
      run_q     <= 1'b0;
      pc_q      <= RESET_VECTOR;
      redir_q   <= '0;
      ir_q      <= '0;
      pc4_q     <= '0;
      vld_q     <= 1'b0;
      buf_ir_q  <= '0;
      buf_pc4_q <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      pc_q      <= pc_d;
      redir_q   <= redir_d;
      ir_q      <= ir_d;
      pc4_q     <= pc4_d;
      vld_q     <= vld_d;
      buf_ir_q  <= buf_ir_d;
      buf_pc4_q <= buf_pc4_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    redir_d   = redir_q;
    ir_d      = ir_q;
    pc4_d     = pc4_q;
    vld_d     = vld_q;
    buf_ir_d  = buf_ir_q;
    buf_pc4_d = buf_pc4_q;
    slot_load = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (rdy && WPCIR) begin
          buf_ir_d  = IMRDATA;
          buf_pc4_d = pc_plus4;
          pc_d      = pc_plus4;
          state_d   = S_HOLD;
        end else if (rdy && take) begin
          pc_d      = tgt;
          slot_load = 1'b1;
        end else if (rdy) begin
          ir_d  = IMRDATA;
          pc4_d = pc_plus4;
          vld_d = 1'b1;
          pc_d  = pc_plus4;
        end else if (take) begin
          // The redirecting instruction moves on; ID sees bubbles until the slot word returns
          redir_d = tgt;
          ir_d    = '0;
          vld_d   = 1'b0;
          state_d = S_DISCARD;
        end else if (!WPCIR && run_q) begin
          ir_d  = '0;
          vld_d = 1'b0;
        end
      end
      S_DISCARD: begin
        if (rdy) begin
          pc_d    = redir_q;
          state_d = S_FETCH;
          if (!WPCIR) begin
            slot_load = 1'b1;
          end else if (SLOT_DELIVER) begin
            buf_ir_d  = IMRDATA;
            buf_pc4_d = pc_plus4;
            state_d   = S_HOLD;
          end
        end else if (!WPCIR) begin
          ir_d  = '0;
          vld_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (!WPCIR) begin
          state_d = S_FETCH;
          if (take) begin
            pc_d      = tgt;
            slot_load = 1'b1;
          end else begin
            ir_d  = buf_ir_q;
            pc4_d = buf_pc4_q;
            vld_d = 1'b1;
          end
        end
      end
      default: state_d = S_FETCH;
    endcase
    if (slot_load) begin
      if (SLOT_DELIVER) begin
        ir_d  = slot_ir;
        pc4_d = slot_pc4;
        vld_d = 1'b1;
      end else begin
        ir_d  = '0;
        vld_d = 1'b0;
      end
    end
  end

  always_comb begin
    IMREQ   = run_q & (state_q != S_HOLD);
    IMADDR  = pc_q;
    IDIR    = ir_q;
    IDPC4   = pc4_q;
    IDVALID = vld_q;
  end

endmodule
